// File: rtl/power_event_ctrl.sv
// Power-event sequencer in the SlowClock domain: turns a debounced power button
// and 3V3 power-good into PS enable, SIO wake pulse, fault flag and state code.
module power_event_ctrl #(
  parameter int unsigned PSON_TIMEOUT_S = 4,
  parameter int unsigned FORCE_OFF_S    = 4,
  parameter int unsigned WAKE_PULSE_T   = 4,
  parameter int unsigned COOLDOWN_T     = 8
) (
  input  logic       SlowClock,
  input  logic       MainReset,
  input  logic       Strobe1s,
  input  logic       Strobe125ms,
  input  logic       PowerButtonDebounce,
  input  logic       PWRGD_PS_PWROK_3V3,
  input  logic       SLP_S3_N,
  output logic       FM_PS_EN,
  output logic [3:0] PowerEvtState,
  output logic       PowerbuttonEvt,
  output logic       PowerFault
);

  typedef enum logic [3:0] {
    ST_STANDBY   = 4'h0,
    ST_POWER_ON  = 4'h1,
    ST_WAKE      = 4'h2,
    ST_RUN       = 4'h3,
    ST_POWER_OFF = 4'h4,
    ST_FAULT     = 4'hF
  } state_t;

  // A limit of N fires on the Nth strobe, i.e. while the count still reads N-1.
  localparam logic [3:0] LP_PSON_LAST  = 4'(PSON_TIMEOUT_S - 1);
  localparam logic [3:0] LP_FORCE_LAST = 4'(FORCE_OFF_S - 1);
  localparam logic [3:0] LP_WAKE_LAST  = 4'(WAKE_PULSE_T - 1);
  localparam logic [3:0] LP_COOL_LAST  = 4'(COOLDOWN_T - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_btn_held;
  logic       r_press;
  logic       r_slp_low;
  logic       r_ps_en;
  logic       r_pwrbtn_n;
  logic       r_fault;

  state_t     w_next_state;
  logic       w_cnt_inc;
  logic       w_cnt_clr;
  logic       w_pressed;
  logic       w_slp_off;

  assign w_pressed = ~PowerButtonDebounce;
  assign w_slp_off = ~SLP_S3_N & r_slp_low;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_cnt_inc    = 1'b0;
    w_cnt_clr    = 1'b0;
    case (r_state)
      ST_STANDBY: begin
        if (r_press) w_next_state = ST_POWER_ON;
      end
      ST_POWER_ON: begin
        if (PWRGD_PS_PWROK_3V3)                    w_next_state = ST_WAKE;
        else if (Strobe1s && r_cnt >= LP_PSON_LAST) w_next_state = ST_FAULT;
        else                                        w_cnt_inc    = Strobe1s;
      end
      ST_WAKE: begin
        if (!PWRGD_PS_PWROK_3V3)                      w_next_state = ST_FAULT;
        else if (Strobe125ms && r_cnt >= LP_WAKE_LAST) w_next_state = ST_RUN;
        else                                           w_cnt_inc    = Strobe125ms;
      end
      ST_RUN: begin
        if (!PWRGD_PS_PWROK_3V3)                                 w_next_state = ST_FAULT;
        else if (w_pressed && Strobe1s && r_cnt >= LP_FORCE_LAST) w_next_state = ST_POWER_OFF;
        else if (w_slp_off)                                       w_next_state = ST_POWER_OFF;
        else if (!w_pressed)                                      w_cnt_clr    = 1'b1;
        else                                                      w_cnt_inc    = Strobe1s;
      end
      ST_POWER_OFF: begin
        // Cooldown only advances once the supply has actually gone away.
        if (!PWRGD_PS_PWROK_3V3 && Strobe125ms && r_cnt >= LP_COOL_LAST)
          w_next_state = ST_STANDBY;
        else
          w_cnt_inc = Strobe125ms & ~PWRGD_PS_PWROK_3V3;
      end
      ST_FAULT: begin
        if (r_press && !PWRGD_PS_PWROK_3V3) w_next_state = ST_POWER_ON;
      end
      default: w_next_state = ST_STANDBY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge SlowClock or negedge MainReset) begin
    if (!MainReset) begin
      r_state    <= ST_STANDBY;
      r_cnt      <= 4'h0;
      // NOTE: history holds the "pressed" sense and resets to 1, so a button held through reset is not an edge.
      r_btn_held <= 1'b1;
      r_press    <= 1'b0;
      r_slp_low  <= 1'b0;
      r_ps_en    <= 1'b0;
      r_pwrbtn_n <= 1'b1;
      r_fault    <= 1'b0;
    end else begin
      r_btn_held <= w_pressed;
      r_press    <= ~r_btn_held & w_pressed;
      r_slp_low  <= ~SLP_S3_N;
      r_state    <= w_next_state;

      if (w_next_state != r_state || w_cnt_clr) r_cnt <= 4'h0;
      else if (w_cnt_inc && r_cnt != 4'hF)      r_cnt <= r_cnt + 4'h1;

      r_ps_en    <= (w_next_state == ST_POWER_ON) || (w_next_state == ST_WAKE) ||
                    (w_next_state == ST_RUN);
      r_pwrbtn_n <= (w_next_state != ST_WAKE);

      if (w_next_state == ST_FAULT)  r_fault <= 1'b1;
      else if (r_state == ST_FAULT)  r_fault <= 1'b0;
    end
  end

  assign FM_PS_EN       = r_ps_en;
  assign PowerEvtState  = r_state;
  assign PowerbuttonEvt = r_pwrbtn_n;
  assign PowerFault     = r_fault;

endmodule

// File: tb/tb_power_event_ctrl.sv
// Directed bench for power_event_ctrl: boot, PSON timeout, forced off, SLP off,
// priority and mid-operation reset, with hand-computed expectations.
module tb_power_event_ctrl;

  logic       SlowClock = 1'b0;
  logic       MainReset;
  logic       Strobe1s;
  logic       Strobe125ms;
  logic       PowerButtonDebounce;
  logic       PWRGD_PS_PWROK_3V3;
  logic       SLP_S3_N;
  logic       FM_PS_EN;
  logic [3:0] PowerEvtState;
  logic       PowerbuttonEvt;
  logic       PowerFault;

  int checks = 0;
  int errors = 0;

  power_event_ctrl dut (
    .SlowClock           (SlowClock),
    .MainReset           (MainReset),
    .Strobe1s            (Strobe1s),
    .Strobe125ms         (Strobe125ms),
    .PowerButtonDebounce (PowerButtonDebounce),
    .PWRGD_PS_PWROK_3V3  (PWRGD_PS_PWROK_3V3),
    .SLP_S3_N            (SLP_S3_N),
    .FM_PS_EN            (FM_PS_EN),
    .PowerEvtState       (PowerEvtState),
    .PowerbuttonEvt      (PowerbuttonEvt),
    .PowerFault          (PowerFault)
  );

  always #5 SlowClock = ~SlowClock;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge SlowClock);
      #1;
    end
  endtask

  task automatic pulse_1s(input int n);
    for (int i = 0; i < n; i++) begin
      Strobe1s = 1'b1;
      tick();
      Strobe1s = 1'b0;
      tick();
    end
  endtask

  task automatic pulse_125(input int n);
    for (int i = 0; i < n; i++) begin
      Strobe125ms = 1'b1;
      tick();
      Strobe125ms = 1'b0;
      tick();
    end
  endtask

  task automatic press();
    PowerButtonDebounce = 1'b0;
    tick(2);
    PowerButtonDebounce = 1'b1;
    tick();
  endtask

  initial begin
    MainReset           = 1'b0;
    Strobe1s            = 1'b0;
    Strobe125ms         = 1'b0;
    PowerButtonDebounce = 1'b1;
    PWRGD_PS_PWROK_3V3  = 1'b0;
    SLP_S3_N            = 1'b1;
    tick(3);
    check("rst_en",    4'(FM_PS_EN),       4'h0);
    check("rst_state", PowerEvtState,      4'h0);
    check("rst_evt",   4'(PowerbuttonEvt), 4'h1);
    check("rst_fault", 4'(PowerFault),     4'h0);
    MainReset = 1'b1;
    tick(2);

    // Normal boot: press-to-enable latency is two cycles.
    PowerButtonDebounce = 1'b0;
    tick();
    check("boot_en_p1",    4'(FM_PS_EN),  4'h0);
    tick();
    check("boot_en_p2",    4'(FM_PS_EN),  4'h1);
    check("boot_state_on", PowerEvtState, 4'h1);
    PowerButtonDebounce = 1'b1;
    pulse_1s(3);
    check("boot_still_on", PowerEvtState, 4'h1);
    PWRGD_PS_PWROK_3V3 = 1'b1;
    tick();
    check("boot_wake",     PowerEvtState,       4'h2);
    check("boot_evt_low",  4'(PowerbuttonEvt),  4'h0);
    pulse_125(3);
    check("wake_evt_3",    4'(PowerbuttonEvt),  4'h0);
    check("wake_state_3",  PowerEvtState,       4'h2);
    pulse_125(1);
    check("run_state",     PowerEvtState,       4'h3);
    check("run_evt_high",  4'(PowerbuttonEvt),  4'h1);
    check("run_en",        4'(FM_PS_EN),        4'h1);

    // Hold released after 3 s: no force-off, counter clears.
    PowerButtonDebounce = 1'b0;
    tick();
    pulse_1s(3);
    PowerButtonDebounce = 1'b1;
    tick();
    pulse_1s(1);
    check("hold3_release", PowerEvtState, 4'h3);

    // Forced off after 4 s of continuous hold.
    PowerButtonDebounce = 1'b0;
    tick();
    pulse_1s(3);
    check("hold_3s", PowerEvtState, 4'h3);
    pulse_1s(1);
    check("force_off_state", PowerEvtState, 4'h4);
    check("force_off_en",    4'(FM_PS_EN),  4'h0);
    PowerButtonDebounce = 1'b1;
    tick();
    press();
    pulse_125(2);
    check("off_ignores_press_pwrok", PowerEvtState, 4'h4);
    PWRGD_PS_PWROK_3V3 = 1'b0;
    tick();
    pulse_125(7);
    check("cooldown_7", PowerEvtState, 4'h4);
    pulse_125(1);
    check("cooldown_8_standby", PowerEvtState, 4'h0);
    check("standby_en",         4'(FM_PS_EN),  4'h0);

    // PSON timeout with PWROK held low.
    press();
    check("pson_on", PowerEvtState, 4'h1);
    pulse_1s(3);
    check("pson_3", PowerEvtState, 4'h1);
    pulse_1s(1);
    check("pson_fault_state", PowerEvtState,   4'hF);
    check("pson_fault_flag",  4'(PowerFault),  4'h1);
    check("pson_fault_en",    4'(FM_PS_EN),    4'h0);
    press();
    check("fault_clear_state", PowerEvtState,  4'h1);
    check("fault_clear_flag",  4'(PowerFault), 4'h0);

    // Priority: PWROK loss beats SLP_S3_N in the same cycle.
    PWRGD_PS_PWROK_3V3 = 1'b1;
    tick();
    pulse_125(4);
    check("prio_run", PowerEvtState, 4'h3);
    PWRGD_PS_PWROK_3V3 = 1'b0;
    SLP_S3_N           = 1'b0;
    tick(3);
    check("prio_state", PowerEvtState,  4'hF);
    check("prio_fault", 4'(PowerFault), 4'h1);
    SLP_S3_N = 1'b1;

    // SLP_S3_N must be low for two consecutive cycles.
    press();
    PWRGD_PS_PWROK_3V3 = 1'b1;
    tick();
    pulse_125(4);
    check("slp_run", PowerEvtState, 4'h3);
    SLP_S3_N = 1'b0;
    tick();
    check("slp_1cyc", PowerEvtState, 4'h3);
    tick();
    check("slp_2cyc", PowerEvtState, 4'h4);
    SLP_S3_N           = 1'b1;
    PWRGD_PS_PWROK_3V3 = 1'b0;
    tick();
    pulse_125(8);
    check("slp_standby", PowerEvtState, 4'h0);

    // Reset mid-Wake with the button held through reset release.
    PowerButtonDebounce = 1'b0;
    tick(2);
    PWRGD_PS_PWROK_3V3 = 1'b1;
    tick();
    check("mid_wake", PowerEvtState, 4'h2);
    MainReset = 1'b0;
    #1;
    check("arst_en",    4'(FM_PS_EN),       4'h0);
    check("arst_state", PowerEvtState,      4'h0);
    check("arst_evt",   4'(PowerbuttonEvt), 4'h1);
    check("arst_fault", 4'(PowerFault),     4'h0);
    PWRGD_PS_PWROK_3V3 = 1'b0;
    tick(2);
    MainReset = 1'b1;
    tick(4);
    check("held_no_poweron_state", PowerEvtState, 4'h0);
    check("held_no_poweron_en",    4'(FM_PS_EN),  4'h0);
    PowerButtonDebounce = 1'b1;
    tick();
    press();
    check("post_reset_press", PowerEvtState, 4'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
